// File: rtl/byte_serial_addsub_pkg.sv
// Shared encodings for the byte-serial adder/subtractor and its 8-bit slice.
package byte_serial_addsub_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/byte_serial_addsub_cell.sv
// Combinational 8-bit add slice: sum bits plus block generate/propagate
// so the caller can form the carry out of the byte as G | (P & Cin).
module eight_bit_cell
  import byte_serial_addsub_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] s_o,
  output logic [BYTE_W-1:0] g_o,
  output logic [BYTE_W-1:0] p_o,
  output logic              bg_o,
  output logic              bp_o
);

  logic carry;
  logic gAcc;

  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;

  always_comb begin
    carry = cin_i;
    s_o   = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s_o[i] = p_o[i] ^ carry;
      carry  = g_o[i] | (p_o[i] & carry);
    end
  end

  // Block generate is independent of the incoming carry.
  always_comb begin
    gAcc = 1'b0;
    for (int i = 0; i < BYTE_W; i++) begin
      gAcc = g_o[i] | (p_o[i] & gAcc);
    end
  end

  assign bg_o = gAcc;
  assign bp_o = &p_o;

endmodule

// File: rtl/byte_serial_addsub.sv
// 32-bit add/subtract computed one byte per clock through a single slice,
// with valid/ready handshakes on the operand and result sides.
module byte_serial_addsub
  import byte_serial_addsub_pkg::*;
#(
  parameter  int NUM_BYTES = 4,
  localparam int W         = 8 * NUM_BYTES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         V,
  output logic         Z
);

  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  state_e state_q, state_d;

  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            v_q, v_d;
  logic            z_q, z_d;

  logic            accept;
  logic            lastByte;
  logic [W-1:0]    aShift;
  logic [W-1:0]    bShift;
  logic [BYTE_W-1:0] cellA, cellB, cellS;
  logic            cellBg, cellBp;
  logic            cellCout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign lastByte = (state_q == RUN) && (idx_q == LAST_IDX);

  // Bring the active byte of each latched operand down to bit 0.
  assign aShift = a_q >> {idx_q, 3'b000};
  assign bShift = b_q >> {idx_q, 3'b000};
  assign cellA  = aShift[BYTE_W-1:0];
  assign cellB  = bShift[BYTE_W-1:0];

  eight_bit_cell u_cell (
    .a_i   (cellA),
    .b_i   (cellB),
    .cin_i (carry_q),
    .s_o   (cellS),
    .g_o   (),
    .p_o   (),
    .bg_o  (cellBg),
    .bp_o  (cellBp)
  );

  assign cellCout = cellBg | (cellBp & carry_q);

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      a_d     = A;
      b_d     = B ^ {W{op_sub}};
      carry_d = (op_sub == OP_SUB);
      idx_d   = '0;
      sum_d   = '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (idx_q == k[IDXW-1:0]) begin
          sum_d[k*BYTE_W +: BYTE_W] = cellS;
        end
      end
      carry_d = cellCout;
      idx_d   = idx_q + 1'b1;
      if (lastByte) begin
        cout_d = cellCout;
        v_d    = (a_q[W-1] == b_q[W-1]) && (cellS[BYTE_W-1] != a_q[W-1]);
        z_d    = (sum_d == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign S    = sum_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule
